// File: rtl/hh_pe_pkg.sv
//==============================================================================
// Module      : hh_pe_pkg
// Description : Shared constants for the HH neuron PE rate-term datapath.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package hh_pe_pkg;
    localparam int CORDIC_W    = 22;
    localparam int CORDIC_SLOT = 22;
    localparam int N_RATE_REQ  = 4;
endpackage

`default_nettype wire

// File: rtl/cordic_div_arbiter_rr.sv
//==============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first requester at or above the
//               pointer, wrapping. One-hot grant plus binary index.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);
    logic [PW:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int k = 0; k < N; k++) begin
            w_j = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_j >= (PW+1)'(N)) begin
                w_j = w_j - (PW+1)'(N);
            end
            if (!o_any && i_req[w_j[PW-1:0]]) begin
                o_any               = 1'b1;
                o_gnt[w_j[PW-1:0]]  = 1'b1;
                o_idx               = w_j[PW-1:0];
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/cordic_div_arbiter.sv
//==============================================================================
// Module      : cordic_div_arbiter
// Description : Shares one free-running CORDIC divider among N_REQ requesters,
//               returning each quotient tagged to its owner; flags a stalled divider.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cordic_div_arbiter
    import hh_pe_pkg::*;
#(
    parameter int N_REQ   = N_RATE_REQ,
    parameter int W       = CORDIC_W,
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*W-1:0] i_req_x,
    input  logic [N_REQ*W-1:0] i_req_y,
    output logic [N_REQ-1:0]   o_ack,
    output logic [N_REQ-1:0]   o_rsp_valid,
    output logic [W-1:0]       o_rsp_data,
    output logic [W-1:0]       o_div_x,
    output logic [W-1:0]       o_div_y,
    input  logic [W-1:0]       i_div_z,
    input  logic               i_div_done,
    output logic               o_busy,
    output logic               o_err_timeout
);
    localparam int c_pw = $clog2(N_REQ);
    localparam int c_cw = $clog2(TIMEOUT + 1);
    localparam logic [c_cw-1:0] c_timeout = c_cw'(TIMEOUT);
    localparam logic [c_pw-1:0] c_last    = c_pw'(N_REQ - 1);

    logic              r_prime;
    logic [c_pw-1:0]   r_ptr;
    logic [c_pw-1:0]   r_owner;
    logic              r_inflight;
    logic [c_cw-1:0]   r_cnt;
    logic              r_err;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [W-1:0]      r_rsp_data;

    logic              w_slot;
    logic [N_REQ-1:0]  w_gnt;
    logic [c_pw-1:0]   w_idx;
    logic              w_any;
    logic [c_pw-1:0]   w_ptr_nxt;
    logic [c_cw-1:0]   w_cnt_nxt;

    // Gating with rst keeps the priming slot from granting while reset is held.
    assign w_slot    = (r_prime | i_div_done) & ~rst;
    assign w_ptr_nxt = (w_idx == c_last) ? '0 : w_idx + 1'b1;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (c_pw)
    ) u_rr (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        o_ack   = '0;
        o_div_x = '0;
        o_div_y = '0;
        if (w_slot && w_any) begin
            o_ack   = w_gnt;
            o_div_x = i_req_x[int'(w_idx)*W +: W];
            o_div_y = i_req_y[int'(w_idx)*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prime    <= 1'b1;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_prime <= 1'b0;
            if (w_slot) begin
                r_inflight <= w_any;
                if (w_any) begin
                    r_ptr   <= w_ptr_nxt;
                    r_owner <= w_idx;
                end
            end
        end
    end

    // The slot that ends op k also returns its quotient, tagged with the saved owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_slot && r_inflight && !r_prime) begin
                r_rsp_valid <= N_REQ'(1) << r_owner;
                r_rsp_data  <= i_div_z;
            end
        end
    end

    assign w_cnt_nxt = w_slot                ? '0    :
                       (r_cnt == c_timeout)  ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == c_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_busy        = r_inflight;
    assign o_err_timeout = r_err;
endmodule

`default_nettype wire

// File: tb/tb_cordic_div_arbiter.sv
//==============================================================================
// Module      : tb_cordic_div_arbiter
// Description : Bench for cordic_div_arbiter with a behavioural 22-clock divider.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cordic_div_arbiter;
    import hh_pe_pkg::*;

    localparam int N  = 4;
    localparam int W  = 22;
    localparam int TO = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [W-1:0] x_arr [N];
    logic [W-1:0] y_arr [N];
    logic [N*W-1:0] req_x, req_y;
    logic [N-1:0] ack, rsp_valid;
    logic [W-1:0] rsp_data, div_x, div_y, div_z;
    logic         div_done, busy, err_timeout;
    logic         stall = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        req_x = '0;
        req_y = '0;
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = x_arr[i];
            req_y[i*W +: W] = y_arr[i];
        end
    end

    cordic_div_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (req),
        .i_req_x       (req_x),
        .i_req_y       (req_y),
        .o_ack         (ack),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_data    (rsp_data),
        .o_div_x       (div_x),
        .o_div_y       (div_y),
        .i_div_z       (div_z),
        .i_div_done    (div_done),
        .o_busy        (busy),
        .o_err_timeout (err_timeout)
    );

    function automatic logic [W-1:0] sdiv(logic [W-1:0] a, logic [W-1:0] b);
        if (b == '0) return '0;
        return W'($signed(a) / $signed(b));
    endfunction

    // Behavioural divider: samples on the first edge after reset and whenever done,
    // raises done 22 edges after each capture; stall suppresses done.
    logic         d_prime;
    logic         d_run;
    int           d_cnt;
    assign div_done = d_run && (d_cnt == 0) && !stall;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_prime <= 1'b1;
            d_run   <= 1'b0;
            d_cnt   <= 0;
            div_z   <= '0;
        end else if (d_prime || div_done) begin
            d_prime <= 1'b0;
            d_run   <= 1'b1;
            d_cnt   <= CORDIC_SLOT - 1;
            div_z   <= sdiv(div_x, div_y);
        end else if (d_cnt > 0) begin
            d_cnt <= d_cnt - 1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_t    = -1;
    int last_g   = -1;
    int ack_who[$], ack_t[$], rsp_who[$], rsp_t[$];
    logic [W-1:0] rsp_d[$];

    // Reference state, kept at the level of the rules: pointer, pending owner, quotient.
    bit           m_prime, m_inflight, m_err;
    int           m_ptr, m_owner, m_cnt;
    logic [N-1:0] m_rv;
    logic [W-1:0] m_rd, m_q;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_prime = 1; m_inflight = 0; m_err = 0;
        m_ptr = 0; m_owner = 0; m_cnt = 0;
        m_rv = '0; m_rd = '0; m_q = '0;
    endtask

    task automatic clr_q();
        ack_who.delete(); ack_t.delete(); rsp_who.delete(); rsp_t.delete(); rsp_d.delete();
        err_t = -1;
    endtask

    // One clock: check every output against the model, then advance the model.
    task automatic tick();
        bit           slot;
        int           g;
        logic [N-1:0] e_ack;
        logic [W-1:0] e_dx, e_dy;
        #1;
        slot = !rst && (m_prime || div_done);
        g = -1;
        if (slot) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        e_ack = (g >= 0) ? (N'(1) << g) : '0;
        e_dx  = (g >= 0) ? x_arr[g] : '0;
        e_dy  = (g >= 0) ? y_arr[g] : '0;
        chk("ack", ack, e_ack);
        chk("div_x", div_x, e_dx);
        chk("div_y", div_y, e_dy);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_data", rsp_data, m_rd);
        chk("busy", busy, m_inflight);
        chk("err_timeout", err_timeout, m_err);
        for (int i = 0; i < N; i++) begin
            if (ack[i])       begin ack_who.push_back(i); ack_t.push_back(cyc); end
            if (rsp_valid[i]) begin rsp_who.push_back(i); rsp_t.push_back(cyc); rsp_d.push_back(rsp_data); end
        end
        if (err_timeout && err_t < 0) err_t = cyc;
        if (rst) begin
            m_reset();
        end else begin
            m_rv = '0;
            if (slot && m_inflight && !m_prime) begin
                m_rv = N'(1) << m_owner;
                m_rd = m_q;
            end
            if (slot) begin
                m_inflight = (g >= 0);
                if (g >= 0) begin
                    m_ptr   = (g + 1) % N;
                    m_owner = g;
                    m_q     = sdiv(x_arr[g], y_arr[g]);
                end
            end
            m_prime = 0;
            m_cnt   = slot ? 0 : ((m_cnt < TO) ? m_cnt + 1 : TO);
            if (m_cnt == TO) m_err = 1;
        end
        last_g = g;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) begin x_arr[i] = '0; y_arr[i] = '0; end
        m_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    int t0, sc, found;

    initial begin
        for (int i = 0; i < N; i++) begin x_arr[i] = '0; y_arr[i] = '0; end
        @(negedge clk);

        // 1: idle after reset
        do_reset();
        clr_q();
        for (int i = 0; i < 100; i++) tick();
        chk("idle_acks", ack_t.size(), 0);
        chk("idle_rsps", rsp_t.size(), 0);

        // 2: single request on the priming slot
        do_reset();
        clr_q();
        req[1] = 1'b1; x_arr[1] = 22'd8192; y_arr[1] = 22'd4096;
        t0 = cyc;
        tick();
        req[1] = 1'b0;
        for (int i = 0; i < 26; i++) tick();
        chk("t2_ack_n", ack_t.size(), 1);
        chk("t2_rsp_n", rsp_t.size(), 1);
        if (ack_t.size() == 1) begin
            chk("t2_ack_who", ack_who[0], 1);
            chk("t2_ack_t", ack_t[0], t0);
        end
        if (rsp_t.size() == 1) begin
            chk("t2_rsp_who", rsp_who[0], 1);
            chk("t2_rsp_t", rsp_t[0], t0 + CORDIC_SLOT + 1);
            chk("t2_rsp_data", rsp_d[0], 2);
        end

        // 3: all requesters held high
        do_reset();
        clr_q();
        req = '1;
        for (int i = 0; i < N; i++) begin x_arr[i] = W'((i + 1) * 4096); y_arr[i] = 22'd4096; end
        for (int i = 0; i < 4 * CORDIC_SLOT + 7; i++) tick();
        req = '0;
        chk("t3_ack_n", ack_t.size(), 5);
        chk("t3_rsp_n", rsp_t.size(), 4);
        if (ack_t.size() == 5 && rsp_t.size() == 4) begin
            for (int k = 0; k < 5; k++) begin
                chk("t3_ack_order", ack_who[k], k % N);
                chk("t3_ack_period", ack_t[k] - ack_t[0], k * CORDIC_SLOT);
            end
            // The return registers on the edge of the next grant, so it shows one cycle later.
            for (int k = 0; k < 4; k++) begin
                chk("t3_rsp_who", rsp_who[k], k);
                chk("t3_rsp_align", rsp_t[k], ack_t[k + 1] + 1);
                chk("t3_rsp_data", rsp_d[k], k + 1);
            end
        end

        // 4: request raised mid-slot waits for the next done
        do_reset();
        clr_q();
        sc = -1;
        for (int i = 0; i < 3 * CORDIC_SLOT && sc < 0; i++) begin
            if (div_done) sc = cyc;
            tick();
        end
        chk("t4_slot_found", sc >= 0, 1);
        for (int i = 0; i < 9; i++) tick();
        req[2] = 1'b1; x_arr[2] = 22'h3FF000; y_arr[2] = 22'd3;
        for (int i = 0; i < 30; i++) tick();
        req[2] = 1'b0;
        chk("t4_ack_n", ack_t.size(), 1);
        chk("t4_rsp_none_yet", rsp_t.size(), 0);
        if (ack_t.size() == 1) begin
            chk("t4_ack_who", ack_who[0], 2);
            chk("t4_ack_t", ack_t[0], sc + CORDIC_SLOT);
        end
        for (int i = 0; i < 20; i++) tick();
        chk("t4_rsp_n", rsp_t.size(), 1);

        // 5: reset while an operation is in flight
        do_reset();
        clr_q();
        req[0] = 1'b1; x_arr[0] = 22'd100; y_arr[0] = 22'd7;
        tick();
        req[0] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        do_reset();
        req[3] = 1'b1; x_arr[3] = 22'd50; y_arr[3] = 22'd0;
        t0 = cyc;
        tick();
        req[3] = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        found = 0;
        foreach (rsp_who[k]) if (rsp_who[k] == 0) found++;
        chk("t5_no_lost_rsp", found, 0);
        chk("t5_ack_n", ack_t.size(), 2);
        if (ack_t.size() == 2) begin
            chk("t5_reprime_who", ack_who[1], 3);
            chk("t5_reprime_t", ack_t[1], t0);
        end
        chk("t5_rsp_n", rsp_t.size(), 1);
        if (rsp_t.size() == 1) chk("t5_div0_data", rsp_d[0], 0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i]   = 1'b1;
                    x_arr[i] = W'($urandom);
                    y_arr[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
                end
            end
            tick();
            if (last_g >= 0) req[last_g] = 1'b0;
        end

        // 6: stalled divider
        stall = 1'b1;
        do_reset();
        clr_q();
        t0 = cyc;
        for (int i = 0; i < 50; i++) tick();
        chk("t6_err_rise", err_t - t0, TO + 1);
        chk("t6_err_sticky", err_timeout, 1);
        stall = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_err_cleared", err_timeout, 0);
        do_reset();
        for (int i = 0; i < 5; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end
endmodule

`default_nettype wire
